// File: rtl/stencil_ub_sched.sv
// stencil_ub_sched: write/read scheduler for a KxK-stencil unified buffer over an IN_W x IN_H tile
module stencil_ub_sched #(
  parameter int IN_W   = 64,
  parameter int IN_H   = 64,
  parameter int K      = 3,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_wen,
  output logic [CTRL_W-1:0] wr_ctrl_vars [2:0],
  input  logic              out_ready,
  output logic              rd_ren,
  output logic [CTRL_W-1:0] rd_ctrl_vars [2:0],
  output logic              rd_data_valid,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(IN_W * IN_H) + 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [CTRL_W-1:0] wx, wy, rx, ry;
  logic [CW-1:0] wcount, thr;
  logic launch, wx_end, rx_end, wlast, rlast, win_ok;
  assign launch   = start & (state == IDLE | state == DONE);
  assign wx_end   = wx == CTRL_W'(IN_W - 1);
  assign rx_end   = rx == CTRL_W'(IN_W - K);
  assign wlast    = wx_end & (wy == CTRL_W'(IN_H - 1));
  assign rlast    = rx_end & (ry == CTRL_W'(IN_H - K));
  // bottom-right pixel of the current window must have been written in an earlier cycle
  assign thr      = (CW'(ry) + CW'(K - 1)) * CW'(IN_W) + CW'(rx) + CW'(K - 1);
  assign win_ok   = wcount > thr;
  assign in_ready = state == RUN;
  assign wr_wen   = in_valid & in_ready;
  assign rd_ren   = (state == RUN | state == DRAIN) & win_ok & out_ready;
  assign busy     = state == RUN | state == DRAIN;
  assign done     = state == DONE;
  always_comb begin
    wr_ctrl_vars[0] = '0;
    wr_ctrl_vars[1] = wx;
    wr_ctrl_vars[2] = wy;
    rd_ctrl_vars[0] = '0;
    rd_ctrl_vars[1] = rx;
    rd_ctrl_vars[2] = ry;
  end
  always_comb begin
    state_n = flush ? IDLE :
              launch ? RUN :
              (state == RUN && wr_wen && wlast) ? DRAIN :
              (state == DRAIN && rd_ren && rlast) ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {wx, wy, rx, ry} <= '0;
      wcount <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_ren & ~flush;
      if (flush | launch) begin
        {wx, wy, rx, ry} <= '0;
        wcount <= '0;
      end else begin
        if (wr_wen) begin
          wx <= wx_end ? '0 : wx + CTRL_W'(1);
          if (wx_end) wy <= wy + CTRL_W'(1);
          wcount <= wcount + CW'(1);
        end
        if (rd_ren) begin
          rx <= rx_end ? '0 : rx + CTRL_W'(1);
          if (rx_end) ry <= ry + CTRL_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_stencil_ub_sched.sv
// tb_stencil_ub_sched: randomized check of two scheduler instances against a count-based tile model
module tb_stencil_ub_sched;
  localparam int CW = 16;
  localparam int K = 3;
  logic clk = 0, rst_n = 0, flush = 0, start_a = 0, start_b = 0, in_valid = 0, out_ready = 0;
  logic a_ir, a_wen, a_ren, a_dv, a_busy, a_done;
  logic b_ir, b_wen, b_ren, b_dv, b_busy, b_done;
  logic [CW-1:0] a_wc [2:0], a_rc [2:0], b_wc [2:0], b_rc [2:0];
  logic o_ir, o_wen, o_ren, o_dv, o_busy, o_done;
  logic [47:0] o_wc, o_rc;
  bit sel = 0;
  int W = 64, H = 64;
  int n_vec = 0, n_err = 0;
  bit started = 0, prev_ren = 0;
  int n_w = 0, n_r = 0, cnt_w, cnt_r, first_nw;
  logic [31:0] last_rd;

  stencil_ub_sched #(.IN_W(64), .IN_H(64), .K(K), .CTRL_W(CW)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start_a), .in_valid(in_valid),
    .in_ready(a_ir), .wr_wen(a_wen), .wr_ctrl_vars(a_wc), .out_ready(out_ready),
    .rd_ren(a_ren), .rd_ctrl_vars(a_rc), .rd_data_valid(a_dv), .busy(a_busy), .done(a_done));
  stencil_ub_sched #(.IN_W(8), .IN_H(6), .K(K), .CTRL_W(CW)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start_b), .in_valid(in_valid),
    .in_ready(b_ir), .wr_wen(b_wen), .wr_ctrl_vars(b_wc), .out_ready(out_ready),
    .rd_ren(b_ren), .rd_ctrl_vars(b_rc), .rd_data_valid(b_dv), .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  assign {o_ir, o_wen, o_ren, o_dv, o_busy, o_done} = sel ?
    {b_ir, b_wen, b_ren, b_dv, b_busy, b_done} : {a_ir, a_wen, a_ren, a_dv, a_busy, a_done};
  assign o_wc = sel ? {b_wc[2], b_wc[1], b_wc[0]} : {a_wc[2], a_wc[1], a_wc[0]};
  assign o_rc = sel ? {b_rc[2], b_rc[1], b_rc[0]} : {a_rc[2], a_rc[1], a_rc[0]};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: a tile is just counts of pixels written and windows read, in raster order
  task automatic step(input bit st, input bit fl, input bit iv, input bit orr);
    int kw, tot, rx, ry;
    bit act, e_ir, e_wen, e_ren;
    @(negedge clk);
    start_a = st & ~sel;
    start_b = st & sel;
    flush = fl;
    in_valid = iv;
    out_ready = orr;
    #1;
    kw = W - K + 1;
    tot = kw * (H - K + 1);
    rx = n_r % kw;
    ry = n_r / kw;
    act = started && n_r < tot;
    e_ir = started && n_w < W * H;
    e_wen = e_ir && iv;
    e_ren = act && orr && n_w > (ry + K - 1) * W + rx + K - 1;
    check("in_ready", 64'(o_ir), 64'(e_ir));
    check("wr_wen", 64'(o_wen), 64'(e_wen));
    check("wr_ctrl", 64'(o_wc), 64'({16'(n_w / W), 16'(n_w % W), 16'd0}));
    check("rd_ren", 64'(o_ren), 64'(e_ren));
    check("rd_ctrl", 64'(o_rc), 64'({16'(ry), 16'(rx), 16'd0}));
    check("rd_dv", 64'(o_dv), 64'(prev_ren));
    check("busy", 64'(o_busy), 64'(act));
    check("done", 64'(o_done), 64'(started && n_r == tot));
    if (o_wen) cnt_w++;
    if (o_ren) begin
      cnt_r++;
      if (cnt_r == 1) first_nw = n_w;
      last_rd = {o_rc[47:32], o_rc[31:16]};
    end
    prev_ren = e_ren && !fl;
    if (fl) begin
      started = 0; n_w = 0; n_r = 0;
    end else if (st && !act) begin
      started = 1; n_w = 0; n_r = 0;
    end else begin
      n_w += int'(e_wen);
      n_r += int'(e_ren);
    end
  endtask

  task automatic async_rst();
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("rst_flags", 64'({o_ir, o_wen, o_ren, o_dv, o_busy, o_done}), 64'(0));
    check("rst_wr_ctrl", 64'(o_wc), 64'(0));
    check("rst_rd_ctrl", 64'(o_rc), 64'(0));
    started = 0; n_w = 0; n_r = 0; prev_ren = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_tile(input int mode, input int flush_at, input int rst_at);
    int burst, tot;
    bit iv, orr;
    burst = 0;
    tot = (W - K + 1) * (H - K + 1);
    cnt_w = 0; cnt_r = 0; first_nw = -1; last_rd = '0;
    step(1, 0, 1, 1);
    for (int c = 0; c < 20000 && !(started && n_r == tot); c++) begin
      if (n_w == flush_at) begin step(0, 1, 1, 1); return; end
      if (n_w == rst_at) begin async_rst(); return; end
      iv = 1; orr = 1;
      if (mode == 1) begin
        orr = ($urandom % 3) != 0;
        if (burst == 0 && $urandom % 60 == 0) burst = 10;
        iv = burst == 0;
        if (burst > 0) burst--;
      end
      step(mode == 1 && $urandom % 400 == 0, 0, iv, orr);
    end
    step(0, 0, 0, 0);
    check("tile_done", 64'(o_done), 64'(1));
    check("wen_total", 64'(cnt_w), 64'(W * H));
    check("ren_total", 64'(cnt_r), 64'(tot));
    check("last_rd", 64'(last_rd), 64'({16'(H - K), 16'(W - K)}));
    if (mode == 0) check("first_rd_wcount", 64'(first_nw), 64'((K - 1) * W + K));
  endtask

  initial begin
    step(0, 0, 1, 1);
    rst_n = 1;
    step(0, 0, 1, 1);
    run_tile(0, -1, -1);
    run_tile(1, -1, -1);
    run_tile(0, 2000, -1);
    run_tile(0, -1, -1);
    run_tile(0, -1, 1500);
    run_tile(1, -1, -1);
    sel = 1; W = 8; H = 6;
    started = 0; n_w = 0; n_r = 0; prev_ren = 0;
    step(0, 0, 0, 0);
    run_tile(0, -1, -1);
    run_tile(1, -1, -1);
    run_tile(1, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
